// File: rtl/wm_pkg.sv
// Shared state encoding and fault codes for the washing-machine sequencer.
package wm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_READY = 4'd1,
    ST_FILL  = 4'd2,
    ST_HEAT  = 4'd3,
    ST_WASH  = 4'd4,
    ST_RINSE = 4'd5,
    ST_SPIN  = 4'd6,
    ST_FAULT = 4'd7
  } wm_state_e;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_FILL_TO = 3'd1;
  localparam logic [2:0] FC_HEAT_TO = 3'd2;
  localparam logic [2:0] FC_OOB     = 3'd3;
  localparam logic [2:0] FC_MOTOR   = 3'd4;
  localparam logic [2:0] FC_LID     = 3'd5;

  // A paid cycle is in progress: extra coins are handed straight back.
  function automatic logic in_service(input wm_state_e s);
    return (s == ST_FILL) || (s == ST_HEAT) || (s == ST_WASH) ||
           (s == ST_RINSE) || (s == ST_SPIN) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Saturating per-phase cycle counter; clear wins over enable.
module wm_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  output logic [TIMER_W-1:0] count
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wm_cycle_controller.sv
// Washing-machine sequencer: coin credit, timed fill/heat, wash/rinse/spin
// passes, latched faults with bounded retry of the failed phase.
module wm_cycle_controller
  import wm_pkg::*;
#(
  parameter int COIN_PRICE    = 2,
  parameter int CREDIT_W      = 4,
  parameter int TIMER_W       = 16,
  parameter int FILL_TIMEOUT  = 1000,
  parameter int HEAT_TIMEOUT  = 2000,
  parameter int RINSE_REPEATS = 2,
  parameter int MAX_RETRY     = 2
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               sig_Coin,
  input  logic                               sig_Lid_Closed,
  input  logic                               sig_Cancel,
  input  logic                               sig_Full,
  input  logic                               sig_Temperature,
  input  logic                               sig_Completed,
  input  logic                               sig_Out_Of_Balance,
  input  logic                               sig_Motor_Failure,
  input  logic                               sig_Fault_Clear,
  output logic [3:0]                         state,
  output logic                               ready,
  output logic                               fill_Water_Operation,
  output logic                               heat_Water_Operation,
  output logic                               wash_Operation,
  output logic                               rinse_Operation,
  output logic                               spin_Operation,
  output logic                               water_Intake,
  output logic                               fault,
  output logic [2:0]                         fault_Code,
  output logic                               fault_Cleared,
  output logic                               coin_Return,
  output logic                               cycle_Done,
  output logic [CREDIT_W-1:0]                credit,
  output logic [$clog2(RINSE_REPEATS+1)-1:0] rinse_Count
);

  localparam int RC_W = $clog2(RINSE_REPEATS + 1);
  localparam int RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  wm_state_e         state_q, state_d;
  wm_state_e         resume_q, resume_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [RC_W-1:0]   rinse_q, rinse_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic [2:0]        fault_code_q, fault_code_d;
  logic              coin_return_q, coin_return_d;
  logic              cycle_done_q, cycle_done_d;
  logic              fault_cleared_q, fault_cleared_d;

  logic                reenter;
  logic                go_fault;
  logic [2:0]          fault_cause;
  logic [CREDIT_W-1:0] credit_plus;
  logic [RC_W-1:0]     rinse_next;
  logic [TIMER_W-1:0]  timer_count;
  logic                timer_clear;
  logic                timer_en;

  // Credit as it would stand after this cycle's coin, saturating at all-ones.
  assign credit_plus = (sig_Coin && (credit_q != '1)) ? credit_q + CREDIT_W'(1) : credit_q;
  assign rinse_next  = rinse_q + RC_W'(1);

  assign timer_clear = (state_d != state_q) || reenter;
  assign timer_en    = (state_q == ST_FILL) || (state_q == ST_HEAT);

  wm_phase_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk   (clock),
    .rst_n (reset_n),
    .clear (timer_clear),
    .enable(timer_en),
    .count (timer_count)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d         = state_q;
    resume_d        = resume_q;
    credit_d        = credit_q;
    rinse_d         = rinse_q;
    retry_d         = retry_q;
    fault_code_d    = fault_code_q;
    coin_return_d   = in_service(state_q) && sig_Coin;
    cycle_done_d    = 1'b0;
    fault_cleared_d = 1'b0;
    reenter         = 1'b0;
    go_fault        = 1'b0;
    fault_cause     = FC_NONE;

    case (state_q)
      ST_IDLE: begin
        if (sig_Cancel && (credit_q != '0)) begin
          coin_return_d = 1'b1;
          credit_d      = '0;
        end else begin
          credit_d = credit_plus;
          if (credit_plus >= CREDIT_W'(COIN_PRICE)) state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (sig_Cancel) begin
          coin_return_d = 1'b1;
          credit_d      = '0;
          state_d       = ST_IDLE;
        end else if (sig_Lid_Closed) begin
          credit_d = credit_plus - CREDIT_W'(COIN_PRICE);
          retry_d  = '0;
          rinse_d  = '0;
          state_d  = ST_FILL;
        end else begin
          credit_d = credit_plus;
        end
      end

      ST_FILL: begin
        if (!sig_Lid_Closed) begin
          go_fault = 1'b1; fault_cause = FC_LID;
        end else if (sig_Full) begin
          state_d = ST_HEAT;
        end else if (timer_count == TIMER_W'(FILL_TIMEOUT - 1)) begin
          go_fault = 1'b1; fault_cause = FC_FILL_TO;
        end
      end

      ST_HEAT: begin
        if (!sig_Lid_Closed) begin
          go_fault = 1'b1; fault_cause = FC_LID;
        end else if (sig_Temperature) begin
          state_d = ST_WASH;
        end else if (timer_count == TIMER_W'(HEAT_TIMEOUT - 1)) begin
          go_fault = 1'b1; fault_cause = FC_HEAT_TO;
        end
      end

      ST_WASH: begin
        if (!sig_Lid_Closed) begin
          go_fault = 1'b1; fault_cause = FC_LID;
        end else if (sig_Completed) begin
          state_d = ST_RINSE;
        end else if (sig_Out_Of_Balance) begin
          go_fault = 1'b1; fault_cause = FC_OOB;
        end
      end

      ST_RINSE: begin
        if (!sig_Lid_Closed) begin
          go_fault = 1'b1; fault_cause = FC_LID;
        end else if (sig_Completed) begin
          rinse_d = rinse_next;
          if (rinse_next == RC_W'(RINSE_REPEATS)) state_d = ST_SPIN;
          else reenter = 1'b1;
        end else if (sig_Motor_Failure) begin
          go_fault = 1'b1; fault_cause = FC_MOTOR;
        end
      end

      ST_SPIN: begin
        if (!sig_Lid_Closed) begin
          go_fault = 1'b1; fault_cause = FC_LID;
        end else if (sig_Completed) begin
          cycle_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (sig_Motor_Failure) begin
          go_fault = 1'b1; fault_cause = FC_MOTOR;
        end else if (sig_Out_Of_Balance) begin
          go_fault = 1'b1; fault_cause = FC_OOB;
        end
      end

      ST_FAULT: begin
        if (sig_Cancel) begin
          coin_return_d   = 1'b1;
          fault_cleared_d = 1'b1;
          fault_code_d    = FC_NONE;
          state_d         = ST_IDLE;
        end else if (sig_Fault_Clear && sig_Lid_Closed) begin
          fault_cleared_d = 1'b1;
          fault_code_d    = FC_NONE;
          if (retry_q < RT_W'(MAX_RETRY)) begin
            retry_d = retry_q + RT_W'(1);
            state_d = resume_q;
          end else begin
            coin_return_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (go_fault) begin
      state_d      = ST_FAULT;
      resume_d     = state_q;
      fault_code_d = fault_cause;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      resume_q        <= ST_IDLE;
      credit_q        <= '0;
      rinse_q         <= '0;
      retry_q         <= '0;
      fault_code_q    <= FC_NONE;
      coin_return_q   <= 1'b0;
      cycle_done_q    <= 1'b0;
      fault_cleared_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples values from before the edge.
      state_q         <= state_d;
      resume_q        <= resume_d;
      credit_q        <= credit_d;
      rinse_q         <= rinse_d;
      retry_q         <= retry_d;
      fault_code_q    <= fault_code_d;
      coin_return_q   <= coin_return_d;
      cycle_done_q    <= cycle_done_d;
      fault_cleared_q <= fault_cleared_d;
    end
  end

  assign state                = state_q;
  assign ready                = (state_q == ST_READY);
  assign fill_Water_Operation = (state_q == ST_FILL);
  assign heat_Water_Operation = (state_q == ST_HEAT);
  assign wash_Operation       = (state_q == ST_WASH);
  assign rinse_Operation      = (state_q == ST_RINSE);
  assign spin_Operation       = (state_q == ST_SPIN);
  assign water_Intake         = (state_q == ST_FILL);
  assign fault                = (state_q == ST_FAULT);
  assign fault_Code           = fault_code_q;
  assign fault_Cleared        = fault_cleared_q;
  assign coin_Return          = coin_return_q;
  assign cycle_Done           = cycle_done_q;
  assign credit               = credit_q;
  assign rinse_Count          = rinse_q;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Directed bench for wm_cycle_controller: a vector table for the main flow
// plus hand-written sequences for timeouts, retries, priorities and reset.
module tb_wm_cycle_controller;

  localparam int FILL_TO = 12;
  localparam int HEAT_TO = 20;

  // Input bit masks: {coin, lid, cancel, full, temp, completed, oob, motor, fault_clear}
  localparam logic [8:0] NONE   = 9'h000;
  localparam logic [8:0] COIN   = 9'h100;
  localparam logic [8:0] LID    = 9'h080;
  localparam logic [8:0] CANCEL = 9'h040;
  localparam logic [8:0] FULL   = 9'h020;
  localparam logic [8:0] TEMP   = 9'h010;
  localparam logic [8:0] COMP   = 9'h008;
  localparam logic [8:0] OOB    = 9'h004;
  localparam logic [8:0] MOTOR  = 9'h002;
  localparam logic [8:0] FCLR   = 9'h001;

  logic clock = 1'b0;
  logic reset_n;
  logic sig_Coin, sig_Lid_Closed, sig_Cancel, sig_Full, sig_Temperature;
  logic sig_Completed, sig_Out_Of_Balance, sig_Motor_Failure, sig_Fault_Clear;
  logic [3:0] state;
  logic ready, fill_Water_Operation, heat_Water_Operation, wash_Operation;
  logic rinse_Operation, spin_Operation, water_Intake, fault;
  logic [2:0] fault_Code;
  logic fault_Cleared, coin_Return, cycle_Done;
  logic [3:0] credit;
  logic [1:0] rinse_Count;

  int n_tests = 0;
  int n_fail  = 0;

  wm_cycle_controller #(
    .COIN_PRICE(2), .CREDIT_W(4), .TIMER_W(16),
    .FILL_TIMEOUT(FILL_TO), .HEAT_TIMEOUT(HEAT_TO),
    .RINSE_REPEATS(2), .MAX_RETRY(2)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .sig_Coin            (sig_Coin),
    .sig_Lid_Closed      (sig_Lid_Closed),
    .sig_Cancel          (sig_Cancel),
    .sig_Full            (sig_Full),
    .sig_Temperature     (sig_Temperature),
    .sig_Completed       (sig_Completed),
    .sig_Out_Of_Balance  (sig_Out_Of_Balance),
    .sig_Motor_Failure   (sig_Motor_Failure),
    .sig_Fault_Clear     (sig_Fault_Clear),
    .state               (state),
    .ready               (ready),
    .fill_Water_Operation(fill_Water_Operation),
    .heat_Water_Operation(heat_Water_Operation),
    .wash_Operation      (wash_Operation),
    .rinse_Operation     (rinse_Operation),
    .spin_Operation      (spin_Operation),
    .water_Intake        (water_Intake),
    .fault               (fault),
    .fault_Code          (fault_Code),
    .fault_Cleared       (fault_Cleared),
    .coin_Return         (coin_Return),
    .cycle_Done          (cycle_Done),
    .credit              (credit),
    .rinse_Count         (rinse_Count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0] in;
    logic [3:0] st;
    logic [3:0] cr;
    logic       cret;
    logic [2:0] fc;
    logic [1:0] rc;
    logic       cd;
    logic       fcl;
  } vec_t;

  vec_t vecs [24];

  // Expected {ready, fill, heat, wash, rinse, spin, water_intake, fault}
  function automatic logic [7:0] flags_for(input logic [3:0] s);
    return {s == 4'd1, s == 4'd2, s == 4'd3, s == 4'd4,
            s == 4'd5, s == 4'd6, s == 4'd2, s == 4'd7};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input logic [3:0] st, input logic [3:0] cr,
                         input logic cret, input logic [2:0] fc, input logic [1:0] rc,
                         input logic cd, input logic fcl);
    logic [7:0] flags_act;
    flags_act = {ready, fill_Water_Operation, heat_Water_Operation, wash_Operation,
                 rinse_Operation, spin_Operation, water_Intake, fault};
    check({n, ".state"}, 32'(state), 32'(st));
    check({n, ".flags"}, 32'(flags_act), 32'(flags_for(st)));
    check({n, ".credit"}, 32'(credit), 32'(cr));
    check({n, ".coin_return"}, 32'(coin_Return), 32'(cret));
    check({n, ".fault_code"}, 32'(fault_Code), 32'(fc));
    check({n, ".rinse_count"}, 32'(rinse_Count), 32'(rc));
    check({n, ".cycle_done"}, 32'(cycle_Done), 32'(cd));
    check({n, ".fault_cleared"}, 32'(fault_Cleared), 32'(fcl));
  endtask

  task automatic cyc(input logic [8:0] v);
    {sig_Coin, sig_Lid_Closed, sig_Cancel, sig_Full, sig_Temperature,
     sig_Completed, sig_Out_Of_Balance, sig_Motor_Failure, sig_Fault_Clear} = v;
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [8:0] v, input string n, input logic [3:0] st,
                      input logic [3:0] cr, input logic cret, input logic [2:0] fc,
                      input logic [1:0] rc, input logic cd, input logic fcl);
    cyc(v);
    chk_out(n, st, cr, cret, fc, rc, cd, fcl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          in            st    cr    cret  fc    rc    cd    fcl
    vecs[0]  = '{COIN,        4'd0, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{NONE,        4'd0, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{COIN,        4'd1, 4'd2, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{NONE,        4'd1, 4'd2, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{LID,         4'd2, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{LID,         4'd2, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{LID | FULL,  4'd3, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{LID | TEMP,  4'd4, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{LID | COMP,  4'd5, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{LID,         4'd5, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{LID | COMP,  4'd5, 4'd0, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0};
    vecs[11] = '{LID | COMP,  4'd6, 4'd0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[12] = '{LID | COMP,  4'd0, 4'd0, 1'b0, 3'd0, 2'd2, 1'b1, 1'b0};
    vecs[13] = '{LID,         4'd0, 4'd0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[14] = '{COIN,        4'd0, 4'd1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[15] = '{CANCEL,      4'd0, 4'd0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[16] = '{NONE,        4'd0, 4'd0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[17] = '{COIN,        4'd0, 4'd1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[18] = '{COIN,        4'd1, 4'd2, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[19] = '{CANCEL,      4'd0, 4'd0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[20] = '{COIN,        4'd0, 4'd1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[21] = '{COIN,        4'd1, 4'd2, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[22] = '{COIN,        4'd1, 4'd3, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0};
    vecs[23] = '{LID,         4'd2, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};

    reset_n = 1'b0;
    {sig_Coin, sig_Lid_Closed, sig_Cancel, sig_Full, sig_Temperature,
     sig_Completed, sig_Out_Of_Balance, sig_Motor_Failure, sig_Fault_Clear} = NONE;
    #12;
    chk_out("reset", 4'd0, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    #10 reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      cyc(vecs[i].in);
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].cr, vecs[i].cret,
              vecs[i].fc, vecs[i].rc, vecs[i].cd, vecs[i].fcl);
    end

    // FILL timeout: FAULT exactly FILL_TO cycles after entry, then retry restarts the timer.
    for (int k = 0; k < FILL_TO - 1; k++) cyc(LID);
    chk_out("fill_hold", 4'd2, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID, "fill_timeout", 4'd7, 4'd1, 1'b0, 3'd1, 2'd0, 1'b0, 1'b0);
    step(LID | FCLR, "fill_retry", 4'd2, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    step(LID, "fill_retry_end", 4'd2, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < FILL_TO - 2; k++) cyc(LID);
    chk_out("fill_hold2", 4'd2, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID, "fill_timeout2", 4'd7, 4'd1, 1'b0, 3'd1, 2'd0, 1'b0, 1'b0);
    step(LID | CANCEL, "fault_cancel", 4'd0, 4'd1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1);
    step(NONE, "fault_cancel_end", 4'd0, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);

    // Coin in WASH is refunded; imbalance retried twice then aborted.
    step(COIN, "s2_ready", 4'd1, 4'd2, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID, "s2_fill", 4'd2, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | FULL, "s2_heat", 4'd3, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | TEMP, "s2_wash", 4'd4, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | COIN, "wash_coin", 4'd4, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID, "wash_coin_end", 4'd4, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      step(LID | OOB, $sformatf("oob%0d", r), 4'd7, 4'd0, 1'b0, 3'd3, 2'd0, 1'b0, 1'b0);
      step(LID | FCLR, $sformatf("oob_retry%0d", r), 4'd4, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    end
    step(LID | OOB, "oob_last", 4'd7, 4'd0, 1'b0, 3'd3, 2'd0, 1'b0, 1'b0);
    step(LID | FCLR, "oob_abort", 4'd0, 4'd0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1);
    step(NONE, "oob_abort_end", 4'd0, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);

    // Same-cycle priorities: completion beats motor in SPIN, lid beats full in FILL.
    step(COIN, "s3_coin1", 4'd0, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(COIN, "s3_ready", 4'd1, 4'd2, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID, "s3_fill", 4'd2, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | FULL, "s3_heat", 4'd3, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | TEMP, "s3_wash", 4'd4, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | COMP, "s3_rinse", 4'd5, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | COMP, "s3_rinse2", 4'd5, 4'd0, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0);
    step(LID | COMP, "s3_spin", 4'd6, 4'd0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0);
    step(LID | COMP | MOTOR, "spin_done_vs_motor", 4'd0, 4'd0, 1'b0, 3'd0, 2'd2, 1'b1, 1'b0);
    step(COIN, "s3b_coin1", 4'd0, 4'd1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0);
    step(COIN, "s3b_ready", 4'd1, 4'd2, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0);
    step(LID, "s3b_fill", 4'd2, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(FULL, "lid_vs_full", 4'd7, 4'd0, 1'b0, 3'd5, 2'd0, 1'b0, 1'b0);
    step(FCLR, "clear_lid_open", 4'd7, 4'd0, 1'b0, 3'd5, 2'd0, 1'b0, 1'b0);
    step(LID | FCLR, "clear_lid_closed", 4'd2, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    step(LID | FULL, "s3b_heat", 4'd3, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | TEMP, "s3b_wash", 4'd4, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | COMP, "s3b_rinse", 4'd5, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | COMP, "s3b_rinse2", 4'd5, 4'd0, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0);
    step(LID | COMP, "s3b_spin", 4'd6, 4'd0, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0);
    step(LID | MOTOR | OOB, "motor_vs_oob", 4'd7, 4'd0, 1'b0, 3'd4, 2'd2, 1'b0, 1'b0);
    step(LID | CANCEL, "s3b_cancel", 4'd0, 4'd0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1);

    // Asynchronous reset mid-HEAT: everything clears at once, no refund pulse.
    step(COIN, "s4_coin1", 4'd0, 4'd1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0);
    step(COIN, "s4_ready", 4'd1, 4'd2, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0);
    step(COIN, "s4_ready_coin", 4'd1, 4'd3, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0);
    step(LID, "s4_fill", 4'd2, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    step(LID | FULL, "s4_heat", 4'd3, 4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    sig_Full = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk_out("reset_in_heat", 4'd0, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    chk_out("reset_held", 4'd0, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    #3 reset_n = 1'b1;
    step(NONE, "post_reset", 4'd0, 4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wm_cycle_controller.md
Name: wm_cycle_controller

Overview:
Parametrised next-generation washing-machine sequencer. Replaces the external time-out input with internal per-phase timers, accepts multi-coin pricing with credit tracking, and supports a configurable rinse repeat count. Faults are latched with a fault code, and the machine can retry the failed phase a bounded number of times. It sits between the panel/sensor inputs and the actuator drivers.

Parameters:
COIN_PRICE, 2, coins required to start a cycle (≥1)
CREDIT_W, 4, credit counter width; saturates at 2^CREDIT_W-1
TIMER_W, 16, phase timer width
FILL_TIMEOUT, 1000, cycles allowed in FILL before a fault
HEAT_TIMEOUT, 2000, cycles allowed in HEAT before a fault
RINSE_REPEATS, 2, number of rinse passes (≥1)
MAX_RETRY, 2, fault clears that resume the failed phase before a forced abort

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
sig_Coin  in  1  one-cycle pulse per inserted coin
sig_Lid_Closed  in  1  level
sig_Cancel  in  1  level; sampled each cycle
sig_Full  in  1  water level reached
sig_Temperature  in  1  target temperature reached
sig_Completed  in  1  current wash/rinse/spin pass done (pulse)
sig_Out_Of_Balance  in  1  drum imbalance
sig_Motor_Failure  in  1  motor fault
sig_Fault_Clear  in  1  operator acknowledge (pulse)
state  out  4  current state encoding
ready, fill_Water_Operation, heat_Water_Operation, wash_Operation, rinse_Operation, spin_Operation  out  1 each  one-hot phase indicators (Moore)
water_Intake  out  1  high in FILL
fault  out  1  high in FAULT
fault_Code  out  3  latched cause; 0 when not in FAULT
fault_Cleared  out  1  one-cycle pulse on FAULT exit
coin_Return  out  1  one-cycle refund pulse
cycle_Done  out  1  one-cycle pulse on SPIN completion
credit  out  CREDIT_W  current credit
rinse_Count  out  $clog2(RINSE_REPEATS+1)  completed rinse passes

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; credit, rinse_Count, retry count, fault_Code, and timer = 0; all outputs 0. Applies mid-cycle with no refund pulse.
- All outputs are registered. Phase flags are decoded from the state register. Pulses are high exactly one cycle.
- States: IDLE=0, READY=1, FILL=2, HEAT=3, WASH=4, RINSE=5, SPIN=6, FAULT=7.
- IDLE: sig_Coin increments credit (saturating). Move to READY on the cycle after credit ≥ COIN_PRICE. sig_Cancel with credit>0: coin_Return pulse, credit=0.
- READY: ready=1. Coins still add credit. Priority: sig_Cancel first (coin_Return pulse, credit=0, go to IDLE), then sig_Lid_Closed (go to FILL, credit -= COIN_PRICE, retry count=0, rinse_Count=0).
- Coins arriving in FILL..FAULT: credit unchanged; coin_Return pulses the next cycle.
- Phase timer: cleared on every state entry, including RINSE re-entry; increments each cycle in FILL and HEAT; saturates.
- Priority in FILL..SPIN, highest first: lid open (code 5) > phase success > phase fault.
- FILL: sig_Full goes to HEAT. Otherwise timer==FILL_TIMEOUT-1 goes to FAULT with code 1.
- HEAT: sig_Temperature goes to WASH. Otherwise timer==HEAT_TIMEOUT-1 goes to FAULT with code 2.
- WASH: sig_Completed goes to RINSE. Otherwise sig_Out_Of_Balance goes to FAULT with code 3.
- RINSE: on sig_Completed, rinse_Count++. If the new count == RINSE_REPEATS go to SPIN; otherwise re-enter RINSE. Otherwise sig_Motor_Failure goes to FAULT with code 4.
- SPIN: sig_Completed goes to IDLE with a cycle_Done pulse. Otherwise sig_Motor_Failure goes to FAULT with code 4; otherwise sig_Out_Of_Balance goes to FAULT with code 3. Motor failure has priority over imbalance.
- On FAULT entry, the originating state is stored in resume_state.
- FAULT: fault=1 and fault_Code is held. Exit rules, in priority order:
  - sig_Cancel: go to IDLE, coin_Return pulse.
  - sig_Fault_Clear while the lid is open: ignored.
  - sig_Fault_Clear with retry < MAX_RETRY: retry++, go to resume_state (timer restarts, rinse_Count kept).
  - sig_Fault_Clear with retry == MAX_RETRY: go to IDLE, coin_Return pulse.
  - Every FAULT exit produces a fault_Cleared pulse, and fault_Code returns to 0.
- The credit arithmetic never underflows, since READY is only entered with credit ≥ COIN_PRICE.

Decomposition:
- Package wm_pkg holds:
  - state localparams (4-bit encoding);
  - fault code constants FC_NONE=0, FC_FILL_TO=1, FC_HEAT_TO=2, FC_OOB=3, FC_MOTOR=4, FC_LID=5.
- One sub-module, wm_phase_timer (TIMER_W). Ports: clear, enable, count; saturating.

Test Plan:
- COIN_PRICE=2. Pulse sig_Coin once: state stays 0, credit=1. Second pulse: state=1 the next cycle. Close lid: state=2, credit=0.
- Normal run with RINSE_REPEATS=2: sig_Full, sig_Temperature, then four sig_Completed pulses. Expect state sequence 2→3→4→5→5→6→0, rinse_Count reaching 2, and one cycle_Done pulse.
- Hold FILL with sig_Full=0: FAULT entered exactly FILL_TIMEOUT cycles after FILL entry, fault_Code=1. sig_Fault_Clear returns to state 2 with the timer restarted and a fault_Cleared pulse.
- WASH with sig_Out_Of_Balance: clear three times with MAX_RETRY=2. The first two clears resume WASH; the third goes to IDLE with coin_Return=1 for one cycle.
- Same-cycle events: sig_Completed and sig_Motor_Failure together in SPIN give IDLE. Lid opening together with sig_Full in FILL gives FAULT with code 5.
- Reset asserted asynchronously in HEAT: outputs 0 and state 0 immediately, no coin_Return pulse. A coin inserted in WASH gives a coin_Return pulse and credit unchanged.
